// File: rtl/video_pkg.sv
// Shared video-pipeline types: reader FSM states, Wishbone cycle-type codes
// and the pixel word width used between the framebuffer and the pixel FIFO.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int PIX_W = 32;

endpackage

// File: rtl/fb_reader.sv
// Framebuffer reader: a Wishbone burst master that fetches the frame in
// raster order and pushes every returned word into the pixel FIFO. Bursts
// are fixed length, never straddle the end of the frame, and are only
// launched when the FIFO reports room for a whole burst.
module fb_reader
  import video_pkg::*;
#(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter int          BURST    = 64,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [31:0]      wb_adr,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [3:0]       wb_sel,
  output logic [2:0]       wb_cti,
  output logic [1:0]       wb_bte,
  input  logic [31:0]      wb_dat_sm,
  input  logic             wb_ack,
  output logic [PIX_W-1:0] fifo_wdata,
  output logic             fifo_write,
  input  logic             fifo_walmost_full,
  output logic             frame_done
);

  localparam int NPIX = HDISP * VDISP;
  // Keep counters at least one bit wide so degenerate sizes still elaborate.
  localparam int PCW  = (NPIX  > 1) ? $clog2(NPIX)  : 1;
  localparam int BCW  = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [PCW-1:0] PIX_LAST  = PCW'(NPIX - 1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST - 1);

  state_t           state_q;
  logic [PCW-1:0]   pix_q;
  logic [PCW-1:0]   pix_d;
  logic [BCW-1:0]   beat_q;
  logic [BCW-1:0]   beat_d;
  logic [31:0]      adr_q;
  logic [31:0]      adr_d;
  logic             stb_q;
  logic [2:0]       cti_q;
  logic [PIX_W-1:0] wdata_q;
  logic             write_q;
  logic             done_q;

  logic pix_wrap;    // current beat carries the final pixel of the frame
  logic last_beat;   // current beat terminates the burst
  logic next_last;   // the beat after an accepted one terminates the burst
  logic start_last;  // a burst launched now consists of a single beat

  // Next counter/address values and burst-termination look-ahead.
  always_comb begin
    pix_wrap   = (pix_q == PIX_LAST);
    pix_d      = pix_wrap ? '0 : pix_q + PCW'(1);
    beat_d     = beat_q + BCW'(1);
    adr_d      = pix_wrap ? BASE_ADR : adr_q + 32'd4;
    last_beat  = (beat_q == BEAT_LAST) || pix_wrap;
    next_last  = (beat_d == BEAT_LAST) || (pix_d == PIX_LAST);
    start_last = (BEAT_LAST == '0) || pix_wrap;
  end

  // Reader FSM with counters, address generation and registered FIFO push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= video_pkg::IDLE;
      pix_q   <= '0;
      beat_q  <= '0;
      adr_q   <= BASE_ADR;
      stb_q   <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      wdata_q <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        video_pkg::IDLE: begin
          // The FIFO flag promises room for a full burst, so it is only
          // consulted here and never while a burst is in flight.
          if (en && !fifo_walmost_full) begin
            state_q <= video_pkg::BURST;
            stb_q   <= 1'b1;
            cti_q   <= start_last ? CTI_EOB : CTI_INCR;
          end
        end
        video_pkg::BURST: begin
          if (wb_ack) begin
            wdata_q <= wb_dat_sm;
            write_q <= 1'b1;
            done_q  <= pix_wrap;
            pix_q   <= pix_d;
            adr_q   <= adr_d;
            if (last_beat) begin
              beat_q  <= '0;
              stb_q   <= 1'b0;
              cti_q   <= CTI_CLASSIC;
              state_q <= video_pkg::GAP;
            end else begin
              beat_q <= beat_d;
              cti_q  <= next_last ? CTI_EOB : CTI_INCR;
            end
          end
        end
        video_pkg::GAP: begin
          // Guarantees at least one idle bus cycle between bursts.
          state_q <= video_pkg::IDLE;
        end
        default: begin
          state_q <= video_pkg::IDLE;
          stb_q   <= 1'b0;
          cti_q   <= CTI_CLASSIC;
        end
      endcase
    end
  end

  assign wb_adr     = adr_q;
  assign wb_cyc     = stb_q;
  assign wb_stb     = stb_q;
  assign wb_we      = 1'b0;
  assign wb_sel     = 4'b1111;
  assign wb_cti     = cti_q;
  assign wb_bte     = 2'b00;
  assign fifo_wdata = wdata_q;
  assign fifo_write = write_q;
  assign frame_done = done_q;

endmodule
